// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if -- handshake and data bundle around the decode/operand-fetch stage.
//   id_*   : instruction from fetch (valid/ready), flush for branch redirect
//   wb_*   : register-file write port driven by writeback
//   ex_*   : registered ALU operands/controls toward execute (valid/ready)
// slave  : the stage itself.  master : the surrounding pipeline (or a bench).
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic            flush;

    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_A;
    logic [XLEN-1:0] ex_B;
    logic [3:0]      ex_alu_control;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_branch;
    logic            ex_illegal;

    modport slave (
        input  id_valid, id_instr, flush, wb_en, wb_addr, wb_data, ex_ready,
        output id_ready, ex_valid, ex_A, ex_B, ex_alu_control, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
    );

    modport master (
        output id_valid, id_instr, flush, wb_en, wb_addr, wb_data, ex_ready,
        input  id_ready, ex_valid, ex_A, ex_B, ex_alu_control, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage -- decode + operand fetch in front of the ALU.
// Decodes a MIPS-style instruction, reads rs/rt from a 32x32 register file
// (r0 hardwired to zero) and registers operands/controls for execute.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset (clears outputs and register file)
//   bus    : id_ex_stage_if.slave (id_* in, ex_* out, wb_* write port, flush)
// Optional feature: define WB_BYPASS_EN to forward a same-cycle writeback into
// the operand read path; otherwise operands see the pre-write register value.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef struct packed {
        logic [3:0] alu;
        logic [4:0] rd;
        logic       use_imm;
        logic       sext;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign op    = bus.id_instr[31:26];
    assign rs    = bus.id_instr[25:21];
    assign rt    = bus.id_instr[20:16];
    assign rd    = bus.id_instr[15:11];
    assign funct = bus.id_instr[5:0];
    assign imm   = bus.id_instr[15:0];

    // ---------------- register file ----------------
    logic [XLEN-1:0] rf [NREGS];
    logic            wb_hit;

    assign wb_hit = bus.wb_en && (bus.wb_addr != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_hit) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    logic [XLEN-1:0] rs_val, rt_val;

    always_comb begin
        rs_val = (rs == 5'd0) ? '0 : rf[rs];
        rt_val = (rt == 5'd0) ? '0 : rf[rt];
`ifdef WB_BYPASS_EN
        // wb_hit already excludes r0, so r0 still reads as zero
        if (wb_hit && bus.wb_addr == rs) rs_val = bus.wb_data;
        if (wb_hit && bus.wb_addr == rt) rt_val = bus.wb_data;
`endif
    end

    // ---------------- decode ----------------
    ctrl_t c;

    always_comb begin
        c     = '0;
        c.alu = ALU_ADD;
        case (op)
            6'b000000: begin
                c.rd        = rd;
                c.reg_write = 1'b1;
                case (funct)
                    6'b100000: c.alu = ALU_ADD;
                    6'b100010: c.alu = ALU_SUB;
                    6'b100100: c.alu = ALU_AND;
                    6'b100101: c.alu = ALU_OR;
                    6'b101010: c.alu = ALU_SLT;
                    default: begin
                        c.rd        = 5'd0;
                        c.reg_write = 1'b0;
                        c.illegal   = 1'b1;
                    end
                endcase
            end
            6'b001000: begin c.alu = ALU_ADD; c.rd = rt; c.reg_write = 1'b1; c.use_imm = 1'b1; c.sext = 1'b1; end
            6'b001010: begin c.alu = ALU_SLT; c.rd = rt; c.reg_write = 1'b1; c.use_imm = 1'b1; c.sext = 1'b1; end
            6'b001100: begin c.alu = ALU_AND; c.rd = rt; c.reg_write = 1'b1; c.use_imm = 1'b1; end
            6'b001101: begin c.alu = ALU_OR;  c.rd = rt; c.reg_write = 1'b1; c.use_imm = 1'b1; end
            6'b100011: begin
                c.alu = ALU_ADD; c.rd = rt; c.reg_write = 1'b1; c.mem_read = 1'b1;
                c.use_imm = 1'b1; c.sext = 1'b1;
            end
            6'b101011: begin c.alu = ALU_ADD; c.mem_write = 1'b1; c.use_imm = 1'b1; c.sext = 1'b1; end
            6'b000100: begin c.alu = ALU_SUB; c.branch = 1'b1; end
            default:   c.illegal = 1'b1;
        endcase
    end

    logic [XLEN-1:0] b_val;

    always_comb begin
        if (!c.use_imm)  b_val = rt_val;
        else if (c.sext) b_val = {{(XLEN-16){imm[15]}}, imm};
        else             b_val = {{(XLEN-16){1'b0}}, imm};
    end

    // ---------------- handshake / output register ----------------
    logic accept;

    assign bus.id_ready = !bus.ex_valid || bus.ex_ready;
    // flush wins: a redirect must never let the wrong-path instruction in
    assign accept = bus.id_valid && bus.id_ready && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ex_valid       <= 1'b0;
            bus.ex_A           <= '0;
            bus.ex_B           <= '0;
            bus.ex_alu_control <= '0;
            bus.ex_rd          <= '0;
            bus.ex_reg_write   <= 1'b0;
            bus.ex_mem_read    <= 1'b0;
            bus.ex_mem_write   <= 1'b0;
            bus.ex_branch      <= 1'b0;
            bus.ex_illegal     <= 1'b0;
        end else if (bus.flush) begin
            bus.ex_valid <= 1'b0;
        end else if (accept) begin
            bus.ex_valid       <= 1'b1;
            bus.ex_A           <= rs_val;
            bus.ex_B           <= b_val;
            bus.ex_alu_control <= c.alu;
            bus.ex_rd          <= c.rd;
            bus.ex_reg_write   <= c.reg_write;
            bus.ex_mem_read    <= c.mem_read;
            bus.ex_mem_write   <= c.mem_write;
            bus.ex_branch      <= c.branch;
            bus.ex_illegal     <= c.illegal;
        end else if (bus.ex_ready) begin
            // payload left as-is; only the valid bit drops
            bus.ex_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32)) bus ();
    id_ex_stage #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a, b;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, ill;
    } exp_t;

    logic [31:0] mrf [32];
    bit          mv;
    exp_t        me;

    function automatic logic [31:0] rval(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
`endif
        return mrf[idx];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t e;
        logic [31:0] s16, z16;
        s16 = 32'(signed'(ins[15:0]));
        z16 = {16'd0, ins[15:0]};
        e = '{a: rval(ins[25:21]), b: rval(ins[20:16]), alu: 4'd2, rd: 5'd0,
              rw: 0, mr: 0, mw: 0, br: 0, ill: 0};
        case (ins[31:26])
            6'd0: begin
                e.rw = 1; e.rd = ins[15:11];
                case (ins[5:0])
                    6'h20: e.alu = 4'd2;
                    6'h22: e.alu = 4'd6;
                    6'h24: e.alu = 4'd0;
                    6'h25: e.alu = 4'd1;
                    6'h2a: e.alu = 4'd7;
                    default: begin e.rw = 0; e.ill = 1; end
                endcase
            end
            6'h08: begin e.alu = 4'd2; e.b = s16; e.rw = 1; e.rd = ins[20:16]; end
            6'h0a: begin e.alu = 4'd7; e.b = s16; e.rw = 1; e.rd = ins[20:16]; end
            6'h0c: begin e.alu = 4'd0; e.b = z16; e.rw = 1; e.rd = ins[20:16]; end
            6'h0d: begin e.alu = 4'd1; e.b = z16; e.rw = 1; e.rd = ins[20:16]; end
            6'h23: begin e.alu = 4'd2; e.b = s16; e.rw = 1; e.mr = 1; e.rd = ins[20:16]; end
            6'h2b: begin e.alu = 4'd2; e.b = s16; e.mw = 1; end
            6'h04: begin e.alu = 4'd6; e.br = 1; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mv = 0;
            for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        end else begin
            bit rdy;
            rdy = !mv || bus.ex_ready;
            if (bus.flush) mv = 0;
            else if (bus.id_valid && rdy) begin me = model_decode(bus.id_instr); mv = 1; end
            else if (bus.ex_ready) mv = 0;
            if (bus.wb_en && bus.wb_addr != 0) mrf[bus.wb_addr] = bus.wb_data;
        end
    end

    // one compare process, every cycle out of reset
    always @(negedge clk) begin
        if (!reset) begin
            chk("ex_valid", 32'(bus.ex_valid), 32'(mv));
            chk("id_ready", 32'(bus.id_ready), 32'(!mv || bus.ex_ready));
            if (mv) begin
                chk("ex_A", bus.ex_A, me.a);
                chk("ex_alu_control", 32'(bus.ex_alu_control), 32'(me.alu));
                chk("flags", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch, bus.ex_illegal}),
                    32'({me.rw, me.mr, me.mw, me.br, me.ill}));
                if (!me.ill) chk("ex_B", bus.ex_B, me.b);
                if (me.rw)   chk("ex_rd", 32'(bus.ex_rd), 32'(me.rd));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en = 1; bus.wb_addr = a; bus.wb_data = d;
        cyc();
        bus.wb_en = 0;
    endtask

    task automatic issue(input logic [31:0] ins);
        bus.id_valid = 1; bus.id_instr = ins;
        cyc();
        bus.id_valid = 0;
    endtask

    initial begin
        bus.id_valid = 0; bus.id_instr = '0; bus.flush = 0;
        bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0; bus.ex_ready = 1;
        cyc(2);
        chk("rst ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst ex_A", bus.ex_A, 32'd0);
        chk("rst ex_B", bus.ex_B, 32'd0);
        chk("rst ctrl", 32'({bus.ex_alu_control, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
                             bus.ex_mem_write, bus.ex_branch, bus.ex_illegal}), 32'd0);
        reset = 0;
        #1 chk("id_ready after reset", 32'(bus.id_ready), 32'd1);

        // add r3,r1,r2
        wr(5'd1, 32'd10); wr(5'd2, 32'd5);
        issue(32'h00221820);
        chk("add A", bus.ex_A, 32'd10);
        chk("add B", bus.ex_B, 32'd5);
        chk("add alu", 32'(bus.ex_alu_control), 32'b0010);
        chk("add rd", 32'(bus.ex_rd), 32'd3);
        chk("add rw", 32'(bus.ex_reg_write), 32'd1);

        // slti r4,r1,-3 ; ori r6,r0,0x8000
        wr(5'd1, 32'd15);
        issue(32'h2824FFFD);
        chk("slti B", bus.ex_B, 32'hFFFFFFFD);
        chk("slti alu", 32'(bus.ex_alu_control), 32'b0111);
        chk("slti rd", 32'(bus.ex_rd), 32'd4);
        issue(32'h34068000);
        chk("ori B", bus.ex_B, 32'h00008000);
        chk("ori A", bus.ex_A, 32'd0);
        cyc();

        // back-pressure: add held while sub waits
        bus.ex_ready = 0;
        bus.id_valid = 1; bus.id_instr = 32'h00221820;
        cyc();
        bus.id_instr = 32'h00222822;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall id_ready", 32'(bus.id_ready), 32'd0);
            chk("stall A", bus.ex_A, 32'd15);
            chk("stall rd", 32'(bus.ex_rd), 32'd3);
        end
        bus.ex_ready = 1;
        cyc();
        bus.id_valid = 0;
        chk("sub alu", 32'(bus.ex_alu_control), 32'b0110);
        chk("sub rd", 32'(bus.ex_rd), 32'd5);
        cyc();

        // writeback to rs in the acceptance cycle
        bus.wb_en = 1; bus.wb_addr = 5'd1; bus.wb_data = 32'hDEADBEEF;
        issue(32'h00222822);
        bus.wb_en = 0;
`ifdef WB_BYPASS_EN
        chk("bypass A", bus.ex_A, 32'hDEADBEEF);
`else
        chk("no-bypass A", bus.ex_A, 32'd15);
`endif
        cyc();

        // beq held, then flushed
        bus.ex_ready = 0;
        issue(32'h10220004);
        chk("beq branch", 32'(bus.ex_branch), 32'd1);
        chk("beq B", bus.ex_B, 32'd5);
        bus.id_valid = 1; bus.id_instr = 32'h00221820; bus.flush = 1;
        cyc();
        bus.flush = 0; bus.id_valid = 0;
        chk("flush ex_valid", 32'(bus.ex_valid), 32'd0);
        bus.ex_ready = 1;
        cyc();

        // r0 stays zero
        wr(5'd0, 32'h00001234);
        issue(32'h00003820);
        chk("r0 A", bus.ex_A, 32'd0);
        chk("r0 B", bus.ex_B, 32'd0);

        // lw / sw / illegal encodings
        issue(32'h8C28FFF0);
        chk("lw B", bus.ex_B, 32'hFFFFFFF0);
        chk("lw mem_read", 32'(bus.ex_mem_read), 32'd1);
        issue(32'hAC220008);
        chk("sw mem_write", 32'(bus.ex_mem_write), 32'd1);
        chk("sw rw", 32'(bus.ex_reg_write), 32'd0);
        issue(32'hFC000000);
        chk("ill valid", 32'(bus.ex_valid), 32'd1);
        chk("ill flag", 32'(bus.ex_illegal), 32'd1);
        chk("ill rw", 32'(bus.ex_reg_write), 32'd0);
        chk("ill alu", 32'(bus.ex_alu_control), 32'b0010);
        issue(32'h0022183F);
        chk("bad funct", 32'(bus.ex_illegal), 32'd1);
        issue(32'h3027000F);
        chk("andi alu", 32'(bus.ex_alu_control), 32'b0000);
        cyc();

        // reset in the middle of a stall
        bus.ex_ready = 0;
        issue(32'h00221820);
        #2 reset = 1;
        #1;
        chk("async rst valid", 32'(bus.ex_valid), 32'd0);
        chk("async rst A", bus.ex_A, 32'd0);
        cyc();
        reset = 0;
        bus.ex_ready = 1;
        issue(32'h00221820);
        chk("post-rst A", bus.ex_A, 32'd0);
        cyc(2);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/operand-fetch stage directly upstream of the ALU: accepts a 32-bit MIPS-style instruction, decodes it, reads two operands from an internal 32×32 register file and registers the values for the ALU. The registered outputs feed the ALU operand and control inputs: A, B and the 4-bit ALU_control. The block also owns the register-file write port used by writeback. It uses a valid/ready handshake so downstream stalls back-pressure fetch.

## Interface
- XLEN, 32, data width of operands and register file
- NREGS, 32, register count; register 0 reads as zero
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  instruction present on id_instr
- id_ready  out  1  stage can accept this cycle
- id_instr  in  32  instruction word
- flush  in  1  discard held instruction (branch redirect)
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write register index
- wb_data  in  XLEN  write data
- ex_valid  out  1  registered outputs hold a valid instruction
- ex_ready  in  1  ALU stage accepts this cycle
- ex_A, ex_B  out  XLEN  ALU operands
- ex_alu_control  out  4  ALU operation code
- ex_rd  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal  out  1  control flags

## Operation
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- R-type (op 000000): funct 100000→ADD, 100010→SUB, 100100→AND, 100101→OR, 101010→SLT. A=R[rs], B=R[rt], ex_rd=rd, reg_write=1.
- addi 001000 ADD, slti 001010 SLT: B=sign-extended imm. andi 001100 AND, ori 001101 OR: B=zero-extended imm. For all four: ex_rd=rt, reg_write=1.
- lw 100011: ADD, B=sext(imm), ex_rd=rt, reg_write=1, mem_read=1. sw 101011: ADD, B=sext(imm), mem_write=1.
- beq 000100: SUB, A=R[rs], B=R[rt], branch=1.
- Any other op or funct: ex_illegal=1. All other flags are 0 and ex_alu_control=0010. The instruction still passes with ex_valid.
- Register file: wb_en with wb_addr≠0 writes wb_data at the clock edge. Writes to register 0 are ignored. Reads of register 0 return 0.

## Timing
- Reset: ex_valid=0, all ex_* outputs 0, every register-file entry 0. id_ready=1 once reset deasserts.
- id_ready = !ex_valid || ex_ready (combinational). Acceptance occurs when id_valid && id_ready.
- Latency: an instruction accepted at edge N is presented on ex_* with ex_valid=1 after edge N.
- When ex_valid && !ex_ready, all ex_* outputs hold stable. Operands are captured at acceptance and are not refreshed by later writebacks.
- ex_valid clears when ex_ready=1 and nothing is accepted that cycle.
- flush has priority over acceptance: at the next edge ex_valid=0, the input is not accepted, and id_ready follows the normal rule.
- Writeback and acceptance in the same cycle with wb_addr matching rs or rt: behaviour is set by the Configuration section.
- Reset asserted mid-operation: outputs clear immediately and the in-flight instruction is lost.

## Configuration
- WB_BYPASS_EN defined: the operand read path forwards wb_data when wb_en && wb_addr≠0 && wb_addr equals the read index. The captured operand is the value being written that cycle.
- Undefined: the captured operand is the pre-write register value. Software must separate a producer and its consumer by one cycle.

## Test plan
- Reset, write R1=10 and R2=5, then issue add r3,r1,r2 (0x00221820) -> ex_A=10, ex_B=5, ex_alu_control=0010, ex_rd=3, ex_reg_write=1.
- R1=15, issue slti r4,r1,-3 (imm 0xFFFD) -> ex_B=0xFFFFFFFD, ex_alu_control=0111, ex_rd=4. Issue ori with imm 0x8000 -> ex_B=0x00008000.
- Hold ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0 and ex_* unchanged. Raise ex_ready -> the next instruction appears one edge later.
- With wb_en=1, wb_addr=1, wb_data=0xDEADBEEF in the acceptance cycle of sub r5,r1,r2 -> ex_A=0xDEADBEEF with WB_BYPASS_EN, old R1 without it.
- Assert flush while ex_valid=1 and ex_ready=0 -> ex_valid=0 at the next edge. Write to r0 -> later reads return 0.
- Opcode 111111 -> ex_valid=1, ex_illegal=1, ex_reg_write=0. Assert reset mid-stall -> ex_valid=0 asynchronously.
